// File: rtl/mult_control.sv
// mult_control: sequencing FSM for an 8-bit shift-add signed multiplier.
// One Run request produces a clear step, ITER add/subtract + shift
// iterations, then a held completion state until Run drops.
// Optional build macro: MULT_CTRL_SKIP_ZERO_EN -- skip the ADD cycle for
// iterations whose multiplier bit M is 0 (variable latency).
module mult_control #(
  parameter int ITER = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Run,
  input  logic                    ClearA_LoadB,
  input  logic                    M,
  output logic                    Clr_Ld,
  output logic                    ClearXA,
  output logic                    Add,
  output logic                    Sub,
  output logic                    Shift,
  output logic                    Busy,
  output logic                    Done,
  output logic [$clog2(ITER)-1:0] Count
);

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADD,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_iter;

  assign last_iter = (count_q == LAST);

  // Next-state and iteration counter decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_START;
      end
      S_START: begin
        count_d = '0;
`ifdef MULT_CTRL_SKIP_ZERO_EN
        state_d = M ? S_ADD : S_SHIFT;
`else
        state_d = S_ADD;
`endif
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_iter) begin
          state_d = S_HOLD;
        end else begin
          count_d = count_q + CW'(1);
`ifdef MULT_CTRL_SKIP_ZERO_EN
          state_d = M ? S_ADD : S_SHIFT;
`else
          state_d = S_ADD;
`endif
        end
      end
      S_HOLD: begin
        // Run must be seen low before another multiply can begin
        if (!Run) begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Output decode; the final iteration subtracts because the top
  // multiplier bit carries negative weight in two's complement
  always_comb begin
    Clr_Ld  = 1'b0;
    ClearXA = 1'b0;
    Add     = 1'b0;
    Sub     = 1'b0;
    Shift   = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Run has priority over an operand load; nothing leaks while in reset
        Clr_Ld = Reset & ClearA_LoadB & ~Run;
      end
      S_START: begin
        ClearXA = 1'b1;
        Busy    = 1'b1;
      end
      S_ADD: begin
        Add  = M & ~last_iter;
        Sub  = M &  last_iter;
        Busy = 1'b1;
      end
      S_SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
      end
      S_HOLD: begin
        Done = 1'b1;
      end
      default: begin
        Clr_Ld = 1'b0;
      end
    endcase
  end

  assign Count = count_q;

endmodule

// File: tb/tb_mult_control.sv
// Directed testbench for mult_control, with a small shift-add datapath
// model used for end-to-end product checks.
module tb_mult_control;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic       M;
  logic       Clr_Ld, ClearXA, Add, Sub, Shift, Busy, Done;
  logic [2:0] Count;

  logic [6:0] outs;
  assign outs = {Clr_Ld, ClearXA, Add, Sub, Shift, Busy, Done};

  int total = 0;
  int bad   = 0;

`ifdef MULT_CTRL_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // datapath model
  logic       m_drv;
  logic       cosim_en;
  logic [7:0] opnd, s_reg, A, B;
  logic       X;
  logic [8:0] sum9, dif9;
  logic       dp_m;

  assign sum9 = {A[7], A} + {s_reg[7], s_reg};
  assign dif9 = {A[7], A} - {s_reg[7], s_reg};
  assign dp_m = (SKIP && Shift) ? B[1] : B[0];
  assign M    = cosim_en ? dp_m : m_drv;

  always @(posedge Clk) begin
    if (Clr_Ld) begin
      X <= 1'b0; A <= 8'h00; B <= opnd;
    end else if (ClearXA) begin
      X <= 1'b0; A <= 8'h00;
    end else if (Add) begin
      X <= sum9[8]; A <= sum9[7:0];
    end else if (Sub) begin
      X <= dif9[8]; A <= dif9[7:0];
    end else if (Shift) begin
      A <= {X, A[7:1]};
      B <= {A[0], B[7:1]};
    end
  end

  mult_control #(.ITER(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .ClearXA      (ClearXA),
    .Add          (Add),
    .Sub          (Sub),
    .Shift        (Shift),
    .Busy         (Busy),
    .Done         (Done),
    .Count        (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Called at cycle 1 (START) after Run was sampled at edge 0
  task automatic run_mult(input string nm, input logic mval, input int hold_c);
    int         shifts;
    int         ec;
    logic [6:0] e;
    bit         skip;
    shifts = 0;
    skip   = SKIP && !mval;
    chk({nm, "_start"}, 32'(outs), 32'(7'b0100010));
    for (int c = 2; c < hold_c; c++) begin
      tick;
      if (skip) begin
        ec = c - 2;
        e  = 7'b0000110;
      end else if (c % 2 == 0) begin
        ec = (c - 2) / 2;
        e  = {2'b00, mval && (ec != 7), mval && (ec == 7), 1'b0, 1'b1, 1'b0};
      end else begin
        ec = (c - 3) / 2;
        e  = 7'b0000110;
      end
      chk($sformatf("%s_c%0d_outs", nm, c), 32'(outs), 32'(e));
      chk($sformatf("%s_c%0d_cnt", nm, c), 32'(Count), 32'(ec));
      if (Shift) shifts++;
    end
    tick;
    chk({nm, "_hold_outs"}, 32'(outs), 32'(7'b0000001));
    chk({nm, "_hold_cnt"}, 32'(Count), 32'd7);
    chk({nm, "_shifts"}, 32'(shifts), 32'd8);
  endtask

  task automatic cosim(input string nm, input logic [7:0] b, input logic [7:0] s,
                       input logic [15:0] exp_p, input int p);
    int c;
    int both;
    both     = 0;
    cosim_en = 1'b1;
    opnd     = b;
    s_reg    = s;
    ClearA_LoadB = 1'b1;
    Run      = 1'b0;
    tick;
    ClearA_LoadB = 1'b0;
    Run      = 1'b1;
    tick;
    c = 1;
    while (!Done && c < 40) begin
      if (Add && Sub) both++;
      tick;
      c++;
    end
    chk({nm, "_done"}, 32'(Done), 32'd1);
    chk({nm, "_latency"}, 32'(c), SKIP ? 32'(10 + p) : 32'd18);
    chk({nm, "_addsub_excl"}, 32'(both), 32'd0);
    chk({nm, "_product"}, 32'({A, B}), 32'(exp_p));
    Run = 1'b0;
    tick;
    cosim_en = 1'b0;
  endtask

  initial begin
    int sh;
    int by;
    cosim_en     = 1'b0;
    opnd         = 8'h00;
    s_reg        = 8'h00;
    m_drv        = 1'b1;
    Reset        = 1'b0;
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    #2;
    tick;
    tick;
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_cnt", 32'(Count), 32'd0);

    // idle load request, then Run wins
    Reset = 1'b1;
    Run   = 1'b0;
    #1;
    chk("idle_clrld", 32'(outs), 32'(7'b1000000));
    Run = 1'b1;
    #1;
    chk("idle_run_wins", 32'(outs), 32'd0);
    tick;
    ClearA_LoadB = 1'b0;
    run_mult("m1", 1'b1, 18);

    // Run held high keeps HOLD, never restarts
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("hold_keep%0d", i), 32'(outs), 32'(7'b0000001));
    end

    // drop Run one cycle, then restart
    Run = 1'b0;
    tick;
    chk("idle_after_hold", 32'(outs), 32'd0);
    chk("idle_cnt", 32'(Count), 32'd0);
    Run   = 1'b1;
    m_drv = 1'b0;
    tick;
    run_mult("m0", 1'b0, SKIP ? 10 : 18);
    Run = 1'b0;
    tick;

    // reset mid-multiply at ADD, Count=4
    m_drv = 1'b1;
    Run   = 1'b1;
    tick;
    for (int i = 0; i < 9; i++) tick;
    chk("mid_cnt", 32'(Count), 32'd4);
    chk("mid_add", 32'(Add), 32'd1);
    Reset        = 1'b0;
    ClearA_LoadB = 1'b1;
    tick;
    chk("midrst1_outs", 32'(outs), 32'd0);
    chk("midrst1_cnt", 32'(Count), 32'd0);
    tick;
    chk("midrst2_outs", 32'(outs), 32'd0);
    Reset        = 1'b1;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    sh = 0;
    by = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (Shift) sh++;
      if (Busy || Done) by++;
    end
    chk("postrst_shifts", 32'(sh), 32'd0);
    chk("postrst_busy", 32'(by), 32'd0);

    // datapath products
    cosim("p07xfd", 8'h07, 8'hFD, 16'hFFEB, 3);
    cosim("pfdx05", 8'hFD, 8'h05, 16'hFFF1, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_control.md
# mult_control

Sequencing controller for the 8-bit shift-add signed multiplier datapath: the X flip-flop, the A and B 8-bit shift registers, and the 9-bit adder/subtractor. It turns one Run request into a clear step, then eight add/subtract-and-shift iterations, and finally a held completion state. It drives the register load/shift enables and adder strobes. It observes only the multiplier LSB M (B[0]).

## Interface
Parameters:
- ITER, 8, number of multiplier bits processed; Count width is $clog2(ITER)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low reset
- Run  in  1  level start request; sampled every Clk edge
- ClearA_LoadB  in  1  idle-time request: load B from operand bus, clear X and A
- M  in  1  current B[0] from datapath
- Clr_Ld  out  1  B parallel load plus X/A clear (IDLE only)
- ClearXA  out  1  clear X and A at start of a multiply
- Add  out  1  load A/X with A + S this cycle
- Sub  out  1  load A/X with A − S this cycle (final iteration only)
- Shift  out  1  Shift_En to X→A→B chain
- Busy  out  1  high from START through the last SHIFT
- Done  out  1  high in HOLD
- Count  out  3  current iteration index 0..7

## Operation
- States: IDLE, START, ADD, SHIFT, HOLD. Count is a 3-bit register.
- IDLE:
  - Run=1 → START.
  - Clr_Ld = ClearA_LoadB & ~Run. Run wins when both are high.
- START:
  - ClearXA=1 and Count←0, for one cycle.
  - → ADD.
- ADD:
  - Count<7: Add=M, Sub=0.
  - Count=7: Sub=M, Add=0.
  - → SHIFT unconditionally.
- SHIFT:
  - Shift=1.
  - Count≠7: Count←Count+1, → ADD.
  - Count=7: → HOLD; Count holds at 7.
- HOLD:
  - Done=1, Count holds.
  - Run=0 → IDLE and Count←0; otherwise stay.
  - A Run held high never restarts a multiply.
- Output rules:
  - Outputs are decoded combinationally from state, Count and M.
  - Add and Sub are never both high.
  - Shift is never high together with Add, Sub, ClearXA or Clr_Ld.
- Inputs ignored outside the listed states:
  - ClearA_LoadB is ignored outside IDLE.
  - M is ignored outside ADD, and outside SHIFT→ADD decisions under the macro.
- Reset=0 at any edge, including mid-multiply:
  - Next state IDLE, Count=0.
  - All outputs 0 (Clr_Ld follows IDLE rule once Reset=1).

## Timing
- Run sampled high at edge 0:
  - START is cycle 1.
  - ADD0 is cycle 2, SHIFT0 is cycle 3, … SHIFT7 is cycle 17.
  - HOLD, with Done=1, is from cycle 18.
- Shift occurs exactly 8 times per multiply, one cycle after each ADD.
- The datapath updates B[0] at the same edge, so M is valid in the next ADD.
- Done falls on the first cycle after Run is sampled low in HOLD.
- A new Run may be sampled one cycle later, from IDLE.
- Busy=1 on cycles 1..17; Busy=0 in IDLE and HOLD.
- Reset released (Reset=1) at edge r: IDLE from cycle r+1. Run high at edge r is ignored.

## Configuration
- Macro MULT_CTRL_SKIP_ZERO_EN.
- Defined:
  - From START or SHIFT (Count≠7), the next state is ADD only if M=1.
  - Otherwise it goes directly to SHIFT, with Count incremented as usual.
  - HOLD is entered at cycle 10 + p, where p is the number of 1s among the 8 M values seen.
  - Product is identical to the undefined build.
- Undefined:
  - ADD is always visited, with Add/Sub gated by M.
  - Fixed latency: HOLD at cycle 18.

## Test plan
- Reset=0 for 2 cycles mid-multiply (state ADD, Count=4) → next cycle: IDLE, Count=0, all outputs 0; no further Shift pulses.
- M held 1, Run pulsed high and held → ClearXA in cycle 1, Add=1 on Count 0..6, Sub=1 on Count 7, 8 Shift pulses; Done from cycle 18 (macro undefined) or cycle 18 (macro defined, p=8) and held while Run=1.
- M held 0, macro defined → no Add/Sub; Shift on cycles 2..9; Done at cycle 10. Macro undefined → Done at cycle 18, Add/Sub never high.
- In IDLE, ClearA_LoadB=1 with Run=0 → Clr_Ld=1. Raise Run in the same cycle → Clr_Ld=0 and START next cycle.
- In HOLD, Run dropped for 1 cycle and then raised → IDLE for exactly one cycle, then START; Count restarts at 0.
- Datapath co-simulation, B=0x07, S=0xFD (−3), macro both ways → A:B=0xFFEB (−21), with Add/Sub mutually exclusive throughout.
